// File: rtl/parser_pkg.sv
// Shared types for the parser/deparser rule-configuration path.
package parser_pkg;

  localparam int unsigned RULE_ADDR_WIDTH = 32;
  localparam int unsigned RULE_DATA_WIDTH = 32;

  // One host command as buffered in the loader FIFO.
  typedef struct packed {
    logic                       wr;
    logic [RULE_ADDR_WIDTH-1:0] addr;
    logic [RULE_DATA_WIDTH-1:0] wdata;
  } rule_cmd_t;

  typedef enum logic [2:0] {
    StIdle,
    StIssueWr,
    StGap,
    StIssueRd,
    StWaitRd,
    StResp
  } loader_state_e;

endpackage

// File: rtl/rule_cmd_fifo.sv
// Command FIFO for the rule loader: synchronous, async active-low reset.
// ready_o is registered so it reads 0 while reset is held.
module rule_cmd_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 65
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  output logic             ready_o,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q, count_d;
  logic             ready_q, ready_d;
  logic             push_en, pop_en;

  assign push_en = push_i & ready_q;
  assign pop_en  = pop_i & (count_q != '0);

  // Occupancy bookkeeping and next ready.
  always_comb begin
    count_d = count_q;
    unique case ({push_en, pop_en})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
    ready_d = (count_d < CntW'(Depth));
  end

  // Pointers, count and ready; pointers wrap naturally since Depth is a power of 2.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b0;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop_en)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_d;
      ready_q <= ready_d;
    end
  end

  // Storage needs no reset; the pointers define validity.
  always_ff @(posedge clk_i) begin
    if (push_en) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign ready_o = ready_q;

endmodule

// File: rtl/parser_rule_loader.sv
// Rule-configuration bus initiator: buffers host commands, issues one
// wren/rden strobe per command, waits for read data with a timeout and
// returns one response per command, in order.
// Optional macro PARSER_RULE_WR_VERIFY_EN: read back every write and flag
// a mismatch or timeout in the write response.
module parser_rule_loader
  import parser_pkg::*;
#(
  parameter int unsigned CMD_DEPTH   = 4,
  parameter int unsigned TIMEOUT_CYC = 64,
  parameter int unsigned WR_GAP      = 0
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_cmd_valid,
  output logic                       o_cmd_ready,
  input  logic                       i_cmd_wr,
  input  logic [RULE_ADDR_WIDTH-1:0] i_cmd_addr,
  input  logic [RULE_DATA_WIDTH-1:0] i_cmd_wdata,
  output logic                       o_resp_valid,
  input  logic                       i_resp_ready,
  output logic [RULE_DATA_WIDTH-1:0] o_resp_rdata,
  output logic                       o_resp_err,
  output logic                       o_rule_wren,
  output logic                       o_rule_rden,
  output logic [RULE_ADDR_WIDTH-1:0] o_rule_addr,
  output logic [RULE_DATA_WIDTH-1:0] o_rule_wdata,
  input  logic                       i_rule_rdata_valid,
  input  logic [RULE_DATA_WIDTH-1:0] i_rule_rdata,
  output logic                       o_busy
);

`ifdef PARSER_RULE_WR_VERIFY_EN
  localparam bit VerifyEn = 1'b1;
`else
  localparam bit VerifyEn = 1'b0;
`endif

  localparam int unsigned TmrW    = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned TmrLast = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;
  localparam int unsigned GapW    = (WR_GAP > 1) ? $clog2(WR_GAP) : 1;
  localparam int unsigned GapLast = (WR_GAP > 0) ? WR_GAP - 1 : 0;

  loader_state_e state_q, state_d;
  rule_cmd_t     push_cmd, fifo_cmd;
  logic [$bits(rule_cmd_t)-1:0] fifo_rdata;
  logic          fifo_empty, pop;

  logic                       cmd_wr_q, cmd_wr_d;
  logic [RULE_DATA_WIDTH-1:0] cmd_wdata_q, cmd_wdata_d;
  logic [RULE_ADDR_WIDTH-1:0] rule_addr_q, rule_addr_d;
  logic [RULE_DATA_WIDTH-1:0] rule_wdata_q, rule_wdata_d;
  logic [RULE_DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
  logic                       resp_err_q, resp_err_d;
  logic [TmrW-1:0]            timer_q, timer_d;
  logic [GapW-1:0]            gap_q, gap_d;
  logic                       wren_q, rden_q;
  logic                       timeout;

  assign push_cmd = '{wr: i_cmd_wr, addr: i_cmd_addr, wdata: i_cmd_wdata};
  assign fifo_cmd = rule_cmd_t'(fifo_rdata);
  assign pop      = (state_q == StIdle) && !fifo_empty;
  assign timeout  = (timer_q == TmrW'(TmrLast));

  rule_cmd_fifo #(
    .Depth (CMD_DEPTH),
    .Width ($bits(rule_cmd_t))
  ) u_cmd_fifo (
    .clk_i   (i_clk),
    .rst_ni  (i_rst_n),
    .push_i  (i_cmd_valid),
    .data_i  (push_cmd),
    .ready_o (o_cmd_ready),
    .pop_i   (pop),
    .data_o  (fifo_rdata),
    .empty_o (fifo_empty)
  );

  // State register plus registered strobes and datapath.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= StIdle;
      cmd_wr_q     <= 1'b0;
      cmd_wdata_q  <= '0;
      rule_addr_q  <= '0;
      rule_wdata_q <= '0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      timer_q      <= '0;
      gap_q        <= '0;
      wren_q       <= 1'b0;
      rden_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cmd_wr_q     <= cmd_wr_d;
      cmd_wdata_q  <= cmd_wdata_d;
      rule_addr_q  <= rule_addr_d;
      rule_wdata_q <= rule_wdata_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      timer_q      <= timer_d;
      gap_q        <= gap_d;
      wren_q       <= (state_d == StIssueWr);
      rden_q       <= (state_d == StIssueRd);
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (!fifo_empty) state_d = fifo_cmd.wr ? StIssueWr : StIssueRd;
      StIssueWr: begin
        if (WR_GAP > 0) state_d = StGap;
        else            state_d = VerifyEn ? StIssueRd : StResp;
      end
      StGap:     if (gap_q == GapW'(GapLast)) state_d = VerifyEn ? StIssueRd : StResp;
      StIssueRd: state_d = StWaitRd;
      StWaitRd:  if (i_rule_rdata_valid || timeout) state_d = StResp;
      StResp:    if (i_resp_ready) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Datapath: latch command on pop, run timers, capture the response.
  always_comb begin
    cmd_wr_d     = cmd_wr_q;
    cmd_wdata_d  = cmd_wdata_q;
    rule_addr_d  = rule_addr_q;
    rule_wdata_d = rule_wdata_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    timer_d      = timer_q;
    gap_d        = gap_q;
    if (pop) begin
      cmd_wr_d     = fifo_cmd.wr;
      cmd_wdata_d  = fifo_cmd.wdata;
      rule_addr_d  = fifo_cmd.addr;
      rule_wdata_d = fifo_cmd.wr ? fifo_cmd.wdata : '0;
      resp_rdata_d = '0;
      resp_err_d   = 1'b0;
    end
    // Read strobes always carry zero write data, including verify readback.
    if (state_d == StIssueRd) rule_wdata_d = '0;
    unique case (state_q)
      StIssueWr: gap_d = '0;
      StGap:     gap_d = gap_q + GapW'(1);
      StIssueRd: timer_d = '0;
      StWaitRd: begin
        timer_d = timer_q + TmrW'(1);
        // Data beats a coincident timeout.
        if (i_rule_rdata_valid) begin
          resp_rdata_d = i_rule_rdata;
          resp_err_d   = VerifyEn && cmd_wr_q && (i_rule_rdata != cmd_wdata_q);
        end else if (timeout) begin
          resp_rdata_d = '0;
          resp_err_d   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Outputs.
  always_comb begin
    o_resp_valid = (state_q == StResp);
    o_busy       = (state_q != StIdle) || !fifo_empty;
    o_resp_rdata = resp_rdata_q;
    o_resp_err   = resp_err_q;
    o_rule_wren  = wren_q;
    o_rule_rden  = rden_q;
    o_rule_addr  = rule_addr_q;
    o_rule_wdata = rule_wdata_q;
  end

endmodule

// File: tb/tb_parser_rule_loader.sv
// Directed bench for parser_rule_loader (default parameters).
module tb_parser_rule_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_wr = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic        resp_valid, resp_ready = 1'b1, resp_err;
  logic [31:0] resp_rdata;
  logic        rule_wren, rule_rden, busy;
  logic [31:0] rule_addr, rule_wdata;
  logic        man_valid = 1'b0, auto_valid = 1'b0, auto_pend = 1'b0;
  logic [31:0] man_rdata = '0, auto_rdata = '0, last_wdata = '0;
  logic        rule_rdata_valid;
  logic [31:0] rule_rdata;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int rden_cnt = 0;
  int auto_mode = 0;
  logic [31:0] wren_addr_q[$];
  int          wren_cyc_q[$];

  assign rule_rdata_valid = man_valid | auto_valid;
  assign rule_rdata       = auto_valid ? auto_rdata : man_rdata;

  parser_rule_loader dut (
    .i_clk              (clk),
    .i_rst_n            (rst_n),
    .i_cmd_valid        (cmd_valid),
    .o_cmd_ready        (cmd_ready),
    .i_cmd_wr           (cmd_wr),
    .i_cmd_addr         (cmd_addr),
    .i_cmd_wdata        (cmd_wdata),
    .o_resp_valid       (resp_valid),
    .i_resp_ready       (resp_ready),
    .o_resp_rdata       (resp_rdata),
    .o_resp_err         (resp_err),
    .o_rule_wren        (rule_wren),
    .o_rule_rden        (rule_rden),
    .o_rule_addr        (rule_addr),
    .o_rule_wdata       (rule_wdata),
    .i_rule_rdata_valid (rule_rdata_valid),
    .i_rule_rdata       (rule_rdata),
    .o_busy             (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Strobe monitor and auto-responder (mode 1 echoes, mode 2 flips bit 0).
  always @(negedge clk) begin
    auto_valid = 1'b0;
    if (auto_pend) begin
      auto_valid = 1'b1;
      auto_rdata = (auto_mode == 2) ? (last_wdata ^ 32'h1) : last_wdata;
    end
    auto_pend = (auto_mode != 0) && rule_rden;
    if (rule_wren) begin
      wren_addr_q.push_back(rule_addr);
      wren_cyc_q.push_back(cyc);
      last_wdata = rule_wdata;
    end
    if (rule_rden) rden_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = addr; cmd_wdata = wdata;
  endtask

  task automatic test_reset;
    #1;
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", cmd_ready); end
    checks++; if ({resp_valid, rule_wren, rule_rden, resp_err, busy} !== 5'b0) begin
      errors++; $display("FAIL rst_ctrl: got %b want 00000", {resp_valid, rule_wren, rule_rden, resp_err, busy});
    end
    checks++; if ({rule_addr, rule_wdata, resp_rdata} !== 96'b0) begin
      errors++; $display("FAIL rst_data: got %h want 0", {rule_addr, rule_wdata, resp_rdata});
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_out: got %b want 1", cmd_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy_out: got %b want 0", busy); end
  endtask

  task automatic test_single_write;
`ifdef PARSER_RULE_WR_VERIFY_EN
    auto_mode = 1;
`else
    auto_mode = 0;
`endif
    push_cmd(1'b1, 32'h0103_0000, 32'h0000_0105);             // cycle 0
    @(negedge clk); cmd_valid = 1'b0;                          // cycle 1
    checks++; if (rule_wren !== 1'b0) begin errors++; $display("FAIL wr_c1_wren: got %b want 0", rule_wren); end
    @(negedge clk);                                            // cycle 2
    checks++; if (rule_wren !== 1'b1) begin errors++; $display("FAIL wr_c2_wren: got %b want 1", rule_wren); end
    checks++; if (rule_addr !== 32'h0103_0000) begin errors++; $display("FAIL wr_addr: got %h want 01030000", rule_addr); end
    checks++; if (rule_wdata !== 32'h0000_0105) begin errors++; $display("FAIL wr_wdata: got %h want 00000105", rule_wdata); end
`ifdef PARSER_RULE_WR_VERIFY_EN
    @(negedge clk);                                            // cycle 3: readback
    checks++; if ({rule_rden, rule_wren, resp_valid} !== 3'b100) begin
      errors++; $display("FAIL wrv_c3: got %b want 100", {rule_rden, rule_wren, resp_valid});
    end
    @(negedge clk);                                            // cycle 4
    @(negedge clk);                                            // cycle 5
    checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL wr_resp_valid: got %b want 1", resp_valid); end
    checks++; if (resp_rdata !== 32'h0000_0105) begin errors++; $display("FAIL wr_resp_rdata: got %h want 00000105", resp_rdata); end
`else
    @(negedge clk);                                            // cycle 3
    checks++; if (rule_wren !== 1'b0) begin errors++; $display("FAIL wr_c3_wren: got %b want 0", rule_wren); end
    checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL wr_resp_valid: got %b want 1", resp_valid); end
    checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL wr_resp_rdata: got %h want 0", resp_rdata); end
`endif
    checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL wr_resp_err: got %b want 0", resp_err); end
    @(negedge clk);
    checks++; if ({resp_valid, busy} !== 2'b00) begin errors++; $display("FAIL wr_done: got %b want 00", {resp_valid, busy}); end
    auto_mode = 0;
  endtask

  task automatic test_read;
    int r0;
    auto_mode = 0;
    r0 = rden_cnt;
    push_cmd(1'b0, 32'h0200_0004, 32'h1234_5678);             // cycle 0
    @(negedge clk); cmd_valid = 1'b0;                          // cycle 1
    @(negedge clk);                                            // cycle 2
    checks++; if (rule_rden !== 1'b1) begin errors++; $display("FAIL rd_rden: got %b want 1", rule_rden); end
    checks++; if (rule_addr !== 32'h0200_0004) begin errors++; $display("FAIL rd_addr: got %h want 02000004", rule_addr); end
    checks++; if (rule_wdata !== 32'h0) begin errors++; $display("FAIL rd_wdata: got %h want 0", rule_wdata); end
    repeat (3) @(negedge clk);                                 // cycle 5
    man_valid = 1'b1; man_rdata = 32'hCAFE_0001;
    @(negedge clk); man_valid = 1'b0;                          // cycle 6
    checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL rd_resp_valid: got %b want 1", resp_valid); end
    checks++; if (resp_rdata !== 32'hCAFE_0001) begin errors++; $display("FAIL rd_resp_rdata: got %h want cafe0001", resp_rdata); end
    checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL rd_resp_err: got %b want 0", resp_err); end
    @(negedge clk);
    checks++; if (rden_cnt - r0 !== 1) begin errors++; $display("FAIL rd_rden_count: got %0d want 1", rden_cnt - r0); end
  endtask

  task automatic test_timeout;
    int early;
    early = 0;
    push_cmd(1'b0, 32'h0200_0008, 32'h0);                     // cycle 0
    @(negedge clk); cmd_valid = 1'b0;                          // cycle 1
    @(negedge clk);                                            // cycle 2
    checks++; if (rule_rden !== 1'b1) begin errors++; $display("FAIL to_rden: got %b want 1", rule_rden); end
    for (int c = 3; c <= 66; c++) begin
      @(negedge clk);
      if (resp_valid) early++;
    end
    checks++; if (early !== 0) begin errors++; $display("FAIL to_early: got %0d early responses want 0", early); end
    @(negedge clk);                                            // cycle 67
    checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL to_resp_valid: got %b want 1", resp_valid); end
    checks++; if (resp_err !== 1'b1) begin errors++; $display("FAIL to_resp_err: got %b want 1", resp_err); end
    checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL to_resp_rdata: got %h want 0", resp_rdata); end
    @(negedge clk); man_valid = 1'b1; man_rdata = 32'hDEAD_BEEF;
    @(negedge clk); man_valid = 1'b0;
    early = 0;
    repeat (3) begin
      @(negedge clk);
      if (resp_valid || busy) early++;
    end
    checks++; if (early !== 0) begin errors++; $display("FAIL to_stray: got %0d active cycles want 0", early); end
  endtask

  task automatic test_fifo_full;
    int w, n, guard, spacing;
`ifdef PARSER_RULE_WR_VERIFY_EN
    auto_mode = 1; spacing = 5;
`else
    auto_mode = 0; spacing = 3;
`endif
    resp_ready = 1'b0;
    wren_addr_q.delete();
    wren_cyc_q.delete();
    for (int i = 0; i < 5; i++) begin
      push_cmd(1'b1, 32'h0100_0000 + 32'(i * 4), 32'h100 + 32'(i));
      w = 0;
      while (!cmd_ready && w < 20) begin @(negedge clk); w++; end
      checks++; if (w >= 20) begin errors++; $display("FAIL ff_push%0d: ready stuck low, push not accepted", i); end
    end
    @(negedge clk); cmd_valid = 1'b0;
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL ff_ready_full: got %b want 0", cmd_ready); end
    checks++; if (wren_addr_q.size() !== 1) begin errors++; $display("FAIL ff_stalled_wren: got %0d want 1", wren_addr_q.size()); end
    repeat (5) @(negedge clk);
    checks++; if ({resp_valid, busy} !== 2'b11) begin errors++; $display("FAIL ff_stall: got %b want 11", {resp_valid, busy}); end
    resp_ready = 1'b1;
    n = 0; guard = 0;
    do begin
      if (resp_valid) begin
        n++;
        checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL ff_resp_err: got %b want 0", resp_err); end
      end
      @(negedge clk); guard++;
    end while (n < 5 && guard < 200);
    checks++; if (n !== 5) begin errors++; $display("FAIL ff_resp_count: got %0d want 5", n); end
    checks++; if (wren_addr_q.size() !== 5) begin errors++; $display("FAIL ff_wren_count: got %0d want 5", wren_addr_q.size()); end
    for (int i = 0; i < 5 && i < wren_addr_q.size(); i++) begin
      checks++; if (wren_addr_q[i] !== 32'h0100_0000 + 32'(i * 4)) begin
        errors++; $display("FAIL ff_order%0d: got %h want %h", i, wren_addr_q[i], 32'h0100_0000 + 32'(i * 4));
      end
    end
    for (int i = 1; i < 4 && i + 1 < wren_cyc_q.size(); i++) begin
      checks++; if (wren_cyc_q[i+1] - wren_cyc_q[i] !== spacing) begin
        errors++; $display("FAIL ff_spacing%0d: got %0d want %0d", i, wren_cyc_q[i+1] - wren_cyc_q[i], spacing);
      end
    end
    @(negedge clk);
    checks++; if ({cmd_ready, busy} !== 2'b10) begin errors++; $display("FAIL ff_drained: got %b want 10", {cmd_ready, busy}); end
    auto_mode = 0;
  endtask

  task automatic test_reset_mid;
    auto_mode = 0;
    push_cmd(1'b0, 32'h0200_0010, 32'h0);                     // cycle 0
    @(negedge clk); cmd_valid = 1'b0;                          // cycle 1
    @(negedge clk);                                            // cycle 2: rden
    repeat (2) @(negedge clk);                                 // cycle 4: waiting
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rm_busy_pre: got %b want 1", busy); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({resp_valid, rule_wren, rule_rden, resp_err, busy, cmd_ready} !== 6'b0) begin
      errors++; $display("FAIL rm_ctrl: got %b want 000000", {resp_valid, rule_wren, rule_rden, resp_err, busy, cmd_ready});
    end
    checks++; if ({rule_addr, rule_wdata, resp_rdata} !== 96'b0) begin
      errors++; $display("FAIL rm_data: got %h want 0", {rule_addr, rule_wdata, resp_rdata});
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    checks++; if ({cmd_ready, busy} !== 2'b10) begin errors++; $display("FAIL rm_after: got %b want 10", {cmd_ready, busy}); end
    test_single_write();
  endtask

`ifdef PARSER_RULE_WR_VERIFY_EN
  task automatic test_verify_mismatch;
    int w;
    auto_mode = 2;
    push_cmd(1'b1, 32'h0103_0008, 32'hA5A5_0F0F);
    @(negedge clk); cmd_valid = 1'b0;
    w = 0;
    while (!resp_valid && w < 20) begin @(negedge clk); w++; end
    checks++; if (w >= 20) begin errors++; $display("FAIL vm_resp: got no response want one"); end
    checks++; if (resp_err !== 1'b1) begin errors++; $display("FAIL vm_err: got %b want 1", resp_err); end
    checks++; if (resp_rdata !== 32'hA5A5_0F0E) begin errors++; $display("FAIL vm_rdata: got %h want a5a50f0e", resp_rdata); end
    @(negedge clk);
    auto_mode = 0;
  endtask
`endif

  initial begin
    test_reset();
    test_single_write();
    test_read();
    test_timeout();
    test_fifo_full();
    test_reset_mid();
`ifdef PARSER_RULE_WR_VERIFY_EN
    test_verify_mismatch();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
